// File: rtl/ifu.sv
// Instruction fetch unit: three-state FETCH/EXEC/ERROR sequencer that holds the
// PC and instruction register and computes the next PC for MIPS-style control flow.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  npcop,
  input  logic        branch_taken,
  input  logic [31:0] ext_in,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [15:0] imm,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {FETCH, EXEC, ERROR} state_t;

  state_t      state;
  logic [31:0] npc;
  logic        jr_misaligned;

  assign pc_plus4      = pc + 32'd4;
  assign imem_addr     = pc;
  assign imm           = instr[15:0];
  assign imem_req      = (state == FETCH) && !rst;
  assign jr_misaligned = (npcop == 2'b11) && (rs_data[1:0] != 2'b00);

  // Branch offset is a word count; shifting left by two drops the top bits.
  always_comb begin
    npc = pc_plus4;
    case (npcop)
      2'b00:   npc = pc_plus4;
      2'b01:   npc = branch_taken ? (pc_plus4 + {ext_in[29:0], 2'b00}) : pc_plus4;
      2'b10:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: npc = rs_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (jr_misaligned) begin
              fetch_err <= 1'b1;
              state     <= ERROR;
            end else begin
              pc    <= npc;
              state <= FETCH;
            end
          end
        end
        default: begin
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
          state       <= ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu: inputs change on the falling edge and
// outputs are checked on the falling edge after each rising edge.
module tb_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  npcop;
  logic        branch_taken;
  logic [31:0] ext_in;
  logic [31:0] rs_data;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [15:0] imm;
  logic        instr_valid;
  logic        fetch_err;

  int checks;
  int errors;

  ifu #(.RESET_PC(32'h0000_3000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .npcop        (npcop),
    .branch_taken (branch_taken),
    .ext_in       (ext_in),
    .rs_data      (rs_data),
    .stall        (stall),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr        (instr),
    .imm          (imm),
    .instr_valid  (instr_valid),
    .fetch_err    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs, then move to the next falling edge.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic stl,
                               input logic [1:0] op, input logic bt,
                               input logic [31:0] ext, input logic [31:0] rs);
    imem_ack     = ack;
    imem_rdata   = rdata;
    stall        = stl;
    npcop        = op;
    branch_taken = bt;
    ext_in       = ext;
    rs_data      = rs;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic fetchOne(input logic [31:0] rdata);
    applyStimulus(1'b1, rdata, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic execOne(input logic [1:0] op, input logic bt,
                         input logic [31:0] ext, input logic [31:0] rs);
    applyStimulus(1'b0, 32'h0, 1'b0, op, bt, ext, rs);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0; npcop = 2'b00;
    branch_taken = 1'b0; ext_in = 32'h0; rs_data = 32'h0;
    @(negedge clk);
    @(negedge clk);

    checkOutput("rst_pc",    pc,                 32'h0000_3000);
    checkOutput("rst_instr", instr,              32'h0);
    checkOutput("rst_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("rst_err",   {31'h0, fetch_err},   32'h0);
    checkOutput("rst_req",   {31'h0, imem_req},    32'h0);

    // Sequential fetch with ack tied high: two cycles per instruction.
    rst = 1'b0;
    #1;
    checkOutput("first_req",  {31'h0, imem_req}, 32'h1);
    checkOutput("first_addr", imem_addr,         32'h0000_3000);
    for (int k = 0; k < 3; k++) begin
      checkOutput("seq_fetch_addr",  imem_addr,           32'h0000_3000 + 32'(4 * k));
      checkOutput("seq_fetch_valid", {31'h0, instr_valid}, 32'h0);
      fetchOne(32'h1111_0000 + 32'(k));
      checkOutput("seq_exec_valid", {31'h0, instr_valid}, 32'h1);
      checkOutput("seq_exec_req",   {31'h0, imem_req},    32'h0);
      checkOutput("seq_exec_pc",    pc,                   32'h0000_3000 + 32'(4 * k));
      checkOutput("seq_exec_instr", instr,                32'h1111_0000 + 32'(k));
      execOne(2'b00, 1'b0, 32'h0, 32'h0);
    end
    checkOutput("seq_next_addr", imem_addr, 32'h0000_300C);

    // An ack coinciding with reset must not load the instruction register.
    rst = 1'b1;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    checkOutput("rst_ack_instr", instr, 32'h0);
    checkOutput("rst_ack_pc",    pc,    32'h0000_3000);
    rst = 1'b0;

    // j: {pc_plus4[31:28], instr[25:0], 2'b00}
    fetchOne(32'h0800_0C10);
    checkOutput("j_instr",    instr,    32'h0800_0C10);
    checkOutput("j_pc_plus4", pc_plus4, 32'h0000_3004);
    checkOutput("j_imm",      {16'h0, imm}, 32'h0000_0C10);
    execOne(2'b10, 1'b0, 32'h0, 32'h0);
    checkOutput("j_target", imem_addr, 32'h0000_3040);

    // Branch taken backwards by one word from 0x3010.
    fetchOne(32'h0);
    execOne(2'b11, 1'b0, 32'h0, 32'h0000_3010);
    checkOutput("jr_target", imem_addr, 32'h0000_3010);
    fetchOne(32'h0);
    execOne(2'b01, 1'b1, 32'hFFFF_FFFE, 32'h0);
    checkOutput("br_taken", imem_addr, 32'h0000_300C);
    fetchOne(32'h0);
    execOne(2'b11, 1'b0, 32'h0, 32'h0000_3010);
    fetchOne(32'h0);
    execOne(2'b01, 1'b0, 32'hFFFF_FFFE, 32'h0);
    checkOutput("br_not_taken", imem_addr, 32'h0000_3014);

    // Delayed ack and stall; misaligned jr inputs outside EXEC-with-no-stall are ignored.
    for (int i = 0; i < 4; i++) begin
      checkOutput("wait_req",  {31'h0, imem_req}, 32'h1);
      checkOutput("wait_addr", imem_addr,         32'h0000_3014);
      applyStimulus(i == 3, 32'hCAFE_0001, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0000_3001);
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_valid", {31'h0, instr_valid}, 32'h1);
      checkOutput("stall_pc",    pc,                   32'h0000_3014);
      checkOutput("stall_instr", instr,                32'hCAFE_0001);
      if (i < 2) applyStimulus(1'b1, 32'h0BAD_0BAD, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0000_3001);
      else       applyStimulus(1'b1, 32'h0BAD_0BAD, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    end
    checkOutput("stall_next_addr", imem_addr,          32'h0000_3018);
    checkOutput("stall_no_err",    {31'h0, fetch_err}, 32'h0);

    // PC wrap-around.
    fetchOne(32'h0);
    execOne(2'b11, 1'b0, 32'h0, 32'hFFFF_FFFC);
    checkOutput("wrap_pc", pc, 32'hFFFF_FFFC);
    fetchOne(32'h0);
    execOne(2'b00, 1'b0, 32'h0, 32'h0);
    checkOutput("wrap_addr", imem_addr,          32'h0000_0000);
    checkOutput("wrap_err",  {31'h0, fetch_err}, 32'h0);

    // Misaligned jr: sticky error, no requests, pc held.
    fetchOne(32'h0);
    execOne(2'b11, 1'b0, 32'h0, 32'h0000_3002);
    checkOutput("err_flag",  {31'h0, fetch_err},   32'h1);
    checkOutput("err_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("err_pc",    pc,                   32'h0000_0000);
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    checkOutput("err_sticky", {31'h0, fetch_err}, 32'h1);
    checkOutput("err_no_req", {31'h0, imem_req},  32'h0);
    checkOutput("err_instr",  instr,              32'h0);

    // Asynchronous reset clears the error before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_err", {31'h0, fetch_err}, 32'h0);
    checkOutput("async_rst_pc",  pc,                 32'h0000_3000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("restart_req",  {31'h0, imem_req}, 32'h1);
    checkOutput("restart_addr", imem_addr,         32'h0000_3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
